// File: rtl/fir_mac_filter.sv
// Time-multiplexed FIR filter: one shared MAC, runtime-loadable signed coefficients, valid/ready on both sides.
// Optional build macro FIR_MAC_SATURATE_EN clamps the shifted result instead of wrapping it.
module fir_mac_filter #(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 8,
  parameter int TAPS     = 16,
  parameter int ACC_W    = 32,
  parameter int SHIFT    = 7,
  parameter int COEF_RST = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  in_data,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [DATA_W-1:0]  out_data
);

  localparam int AW = $clog2(TAPS);
  localparam int KW = $clog2(TAPS + 1);
  localparam int PW = DATA_W + COEF_W;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                   state;
  logic signed [DATA_W-1:0] x_line [TAPS];
  logic signed [COEF_W-1:0] coef   [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic [KW-1:0]            k;
  logic [AW-1:0]            tap_idx;
  logic signed [PW-1:0]     prod;
  logic signed [DATA_W-1:0] result;
  logic                     coef_hit;

`ifdef FIR_MAC_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) <<< (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(1) <<< (DATA_W - 1));
  logic signed [ACC_W-1:0] shifted;
`endif

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    tap_idx  = (32'(k) < TAPS) ? k[AW-1:0] : '0;
    prod     = x_line[tap_idx] * coef[tap_idx];
    coef_hit = coef_we && (state == IDLE) && (32'(coef_addr) < TAPS);
`ifdef FIR_MAC_SATURATE_EN
    shifted = acc >>> SHIFT;
    if (shifted > SAT_MAX)      result = SAT_MAX[DATA_W-1:0];
    else if (shifted < SAT_MIN) result = SAT_MIN[DATA_W-1:0];
    else                        result = shifted[DATA_W-1:0];
`else
    result = DATA_W'(acc >>> SHIFT);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      acc       <= '0;
      k         <= '0;
      // NOTE: the delay line and coefficient bank are small register arrays, so they are reset explicitly.
      for (int i = 0; i < TAPS; i++) begin
        x_line[i] <= '0;
        coef[i]   <= COEF_W'(COEF_RST);
      end
    end else begin
      case (state)
        IDLE: begin
          if (coef_hit) coef[coef_addr] <= coef_data;
          if (in_valid) begin
            for (int i = TAPS - 1; i > 0; i--) x_line[i] <= x_line[i-1];
            x_line[0] <= in_data;
            acc       <= '0;
            k         <= '0;
            in_ready  <= 1'b0;
            state     <= MAC;
          end
        end
        MAC: begin
          if (32'(k) < TAPS) begin
            acc <= acc + {{(ACC_W - PW){prod[PW-1]}}, prod};
            k   <= k + KW'(1);
          end else begin
            out_data  <= result;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          // out_data keeps its last value after the handshake; only out_valid drops.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_filter.sv
// Directed bench for fir_mac_filter: step, impulse, overflow, back-pressure, coefficient timing, mid-MAC reset.
module tb_fir_mac_filter;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] in_data = '0;
  logic               coef_we = 1'b0;
  logic [3:0]         coef_addr = '0;
  logic signed [7:0]  coef_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [15:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fir_mac_filter dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic write_coef(input int a, input int v);
    coef_we   = 1'b1;
    coef_addr = 4'(a);
    coef_data = 8'(v);
    @(posedge clk); #1;
    coef_we   = 1'b0;
  endtask

  // Waits for out_valid; lat counts edges since the caller's acceptance edge. Handshakes if out_ready is high.
  task automatic wait_out(input int lat0, output logic signed [15:0] r, output int lat);
    lat = lat0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r = out_data;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_sample(input logic signed [15:0] d, output logic signed [15:0] r, output int lat);
    int w = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(0, r, lat);
  endtask

  task automatic check_step_sequence(input string tag);
    logic signed [15:0] r;
    int lat, exp;
    for (int n = 1; n <= 16; n++) begin
      run_sample(16'sd1000, r, lat);
      exp = n * 8000 / 128;
      n_checks++;
      if (r !== 16'(exp)) begin
        n_fail++;
        $display("FAIL %s_out[%0d]: got %0d, want %0d", tag, n, r, exp);
      end
      n_checks++;
      if (lat !== 17) begin
        n_fail++;
        $display("FAIL %s_latency[%0d]: got %0d, want 17", tag, n, lat);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, out_valid, out_data} !== {1'b1, 1'b0, 16'sd0}) begin
      n_fail++;
      $display("FAIL reset_state: got ready=%0b valid=%0b data=%0d, want ready=1 valid=0 data=0",
               in_ready, out_valid, out_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_step();
    do_reset();
    check_step_sequence("step");
  endtask

  task automatic test_impulse();
    logic signed [15:0] r;
    int lat, exp;
    do_reset();
    for (int k = 0; k < 16; k++) write_coef(k, k + 1);
    for (int n = 0; n <= 16; n++) begin
      run_sample((n == 0) ? 16'sd128 : 16'sd0, r, lat);
      exp = (n < 16) ? n + 1 : 0;
      n_checks++;
      if (r !== 16'(exp)) begin
        n_fail++;
        $display("FAIL impulse_out[%0d]: got %0d, want %0d", n, r, exp);
      end
    end
  endtask

  task automatic test_overflow();
    logic signed [15:0] r, first, exp_pos, exp_neg;
    int lat;
`ifdef FIR_MAC_SATURATE_EN
    exp_pos = 16'sd32767;
    exp_neg = -16'sd32768;
`else
    exp_pos = -16'sd4112;
    exp_neg = 16'sd4096;
`endif
    do_reset();
    for (int k = 0; k < 16; k++) write_coef(k, 127);
    first = '0;
    for (int n = 0; n < 16; n++) begin
      run_sample(16'sd32767, r, lat);
      if (n == 0) first = r;
    end
    n_checks++;
    if (first !== 16'sd32511) begin
      n_fail++;
      $display("FAIL overflow_first: got %0d, want 32511", first);
    end
    n_checks++;
    if (r !== exp_pos) begin
      n_fail++;
      $display("FAIL overflow_pos: got %0d, want %0d", r, exp_pos);
    end
    for (int n = 0; n < 16; n++) run_sample(-16'sd32768, r, lat);
    n_checks++;
    if (r !== exp_neg) begin
      n_fail++;
      $display("FAIL overflow_neg: got %0d, want %0d", r, exp_neg);
    end
  endtask

  task automatic test_back_pressure();
    logic signed [15:0] r;
    int lat;
    do_reset();
    out_ready = 1'b0;
    run_sample(16'sd1000, r, lat);
    n_checks++;
    if (r !== 16'sd62 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_first: got data=%0d valid=%0b, want data=62 valid=1", r, out_valid);
    end
    in_valid = 1'b1;
    in_data  = 16'sd30000;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, 16'sd62}) begin
        n_fail++;
        $display("FAIL bp_stall[%0d]: got valid=%0b ready=%0b data=%0d, want valid=1 ready=0 data=62",
                 c, out_valid, in_ready, out_data);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_release: got valid=%0b ready=%0b, want valid=0 ready=1", out_valid, in_ready);
    end
    run_sample(16'sd1000, r, lat);
    n_checks++;
    if (r !== 16'sd125) begin
      n_fail++;
      $display("FAIL bp_history: got %0d, want 125", r);
    end
  endtask

  task automatic test_coef_timing();
    logic signed [15:0] r;
    int lat;
    do_reset();
    in_valid = 1'b1;
    in_data  = 16'sd1000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    write_coef(0, 127);
    wait_out(4, r, lat);
    n_checks++;
    if (r !== 16'sd62) begin
      n_fail++;
      $display("FAIL coef_write_in_mac: got %0d, want 62", r);
    end
    coef_we   = 1'b1;
    coef_addr = 4'd0;
    coef_data = 8'sd16;
    in_valid  = 1'b1;
    in_data   = 16'sd1000;
    @(posedge clk); #1;
    coef_we  = 1'b0;
    in_valid = 1'b0;
    wait_out(0, r, lat);
    n_checks++;
    if (r !== 16'sd187) begin
      n_fail++;
      $display("FAIL coef_write_same_edge: got %0d, want 187", r);
    end
  endtask

  task automatic test_reset_mid_mac();
    logic signed [15:0] r;
    int lat;
    do_reset();
    write_coef(0, 100);
    run_sample(16'sd1000, r, lat);
    n_checks++;
    if (r !== 16'sd781) begin
      n_fail++;
      $display("FAIL midrst_pre: got %0d, want 781", r);
    end
    in_valid = 1'b1;
    in_data  = 16'sd1000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, in_ready, out_data} !== {1'b0, 1'b1, 16'sd0}) begin
      n_fail++;
      $display("FAIL midrst_state: got valid=%0b ready=%0b data=%0d, want valid=0 ready=1 data=0",
               out_valid, in_ready, out_data);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    check_step_sequence("midrst_step");
  endtask

  initial begin
    test_reset();
    test_step();
    test_impulse();
    test_overflow();
    test_back_pressure();
    test_coef_timing();
    test_reset_mid_mac();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
